// File: rtl/div_sqrt_arbiter_tp.sv
// Round-robin front-end sharing one divide/square-root unit between NUM_REQ
// requesters; one operation in flight, operands held stable until the next grant.
module div_sqrt_arbiter_tp #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RBI,
    input  logic [NUM_REQ-1:0]     Req_valid_SI,
    output logic [NUM_REQ-1:0]     Req_ready_SO,
    input  logic [NUM_REQ-1:0]     Req_sqrt_SI,
    input  logic [NUM_REQ*32-1:0]  Req_operand_a_DI,
    input  logic [NUM_REQ*32-1:0]  Req_operand_b_DI,
    input  logic [NUM_REQ*2-1:0]   Req_rm_DI,
    input  logic [NUM_REQ*6-1:0]   Req_pc_DI,
    output logic                   Resp_valid_SO,
    input  logic                   Resp_ready_SI,
    output logic [ID_W-1:0]        Resp_id_DO,
    output logic [31:0]            Resp_result_DO,
    output logic [2:0]             Resp_flags_DO,
    output logic                   Busy_SO,
    output logic                   Div_start_SO,
    output logic                   Sqrt_start_SO,
    output logic [31:0]            Operand_a_DO,
    output logic [31:0]            Operand_b_DO,
    output logic [1:0]             RM_SO,
    output logic [5:0]             Precision_ctl_SO,
    input  logic                   Unit_ready_SI,
    input  logic                   Unit_done_SI,
    input  logic [31:0]            Unit_result_DI,
    input  logic [2:0]             Unit_flags_DI
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            grant;

    logic            sel_sqrt;
    logic [31:0]     sel_a, sel_b;
    logic [1:0]      sel_rm;
    logic [5:0]      sel_pc;

    logic            hold_sqrt_q;
    logic [31:0]     hold_a_q, hold_b_q;
    logic [1:0]      hold_rm_q;
    logic [5:0]      hold_pc_q;
    logic [ID_W-1:0] hold_id_q;
    logic [31:0]     resp_result_q;
    logic [2:0]      resp_flags_q;

    // Lowest valid index overall is the wrap-around fallback; the lowest valid
    // index at or above rr_ptr overrides it when one exists.
    // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (Req_valid_SI[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (Req_valid_SI[j] && (ID_W'(j) >= rr_ptr_q)) begin
                grant_idx = ID_W'(j);
            end
        end
    end

    always_comb begin
        sel_sqrt = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        sel_rm   = '0;
        sel_pc   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == grant_idx) begin
                sel_sqrt = Req_sqrt_SI[j];
                sel_a    = Req_operand_a_DI[32*j +: 32];
                sel_b    = Req_operand_b_DI[32*j +: 32];
                sel_rm   = Req_rm_DI[2*j +: 2];
                sel_pc   = Req_pc_DI[6*j +: 6];
            end
        end
    end

    assign grant = (state_q == IDLE) && grant_found;

    // Gated by reset so no requester sees an accept while the block is held in reset.
    assign Req_ready_SO = (grant && Rst_RBI) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found)   state_d = ISSUE;
            ISSUE:   if (Unit_ready_SI) state_d = BUSY;
            BUSY:    if (Unit_done_SI)  state_d = RESP;
            RESP:    if (Resp_ready_SI) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            hold_sqrt_q   <= 1'b0;
            hold_a_q      <= '0;
            hold_b_q      <= '0;
            hold_rm_q     <= '0;
            hold_pc_q     <= '0;
            hold_id_q     <= '0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                hold_sqrt_q <= sel_sqrt;
                hold_a_q    <= sel_a;
                hold_b_q    <= sel_b;
                hold_rm_q   <= sel_rm;
                hold_pc_q   <= sel_pc;
                hold_id_q   <= grant_idx;
                rr_ptr_q    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            if ((state_q == BUSY) && Unit_done_SI) begin
                resp_result_q <= Unit_result_DI;
                resp_flags_q  <= Unit_flags_DI;
            end
        end
    end

    assign Div_start_SO     = (state_q == ISSUE) && Unit_ready_SI && !hold_sqrt_q;
    assign Sqrt_start_SO    = (state_q == ISSUE) && Unit_ready_SI &&  hold_sqrt_q;
    assign Operand_a_DO     = hold_a_q;
    assign Operand_b_DO     = hold_b_q;
    assign RM_SO            = hold_rm_q;
    assign Precision_ctl_SO = hold_pc_q;
    assign Busy_SO          = (state_q != IDLE);
    assign Resp_valid_SO    = (state_q == RESP);
    assign Resp_id_DO       = hold_id_q;
    assign Resp_result_DO   = resp_result_q;
    assign Resp_flags_DO    = resp_flags_q;

endmodule

// File: tb/tb_div_sqrt_arbiter_tp.sv
// Bench for div_sqrt_arbiter_tp with NUM_REQ=4: a behavioural unit stub computes
// real-valued div/sqrt, and a round-robin reference predicts grants and responses.
module tb_div_sqrt_arbiter_tp;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_sqrt  = '0;
    logic [N*32-1:0] req_a     = '0;
    logic [N*32-1:0] req_b     = '0;
    logic [N*2-1:0]  req_rm    = '0;
    logic [N*6-1:0]  req_pc    = '0;
    logic            resp_ready = 1'b0;
    logic            unit_ready = 1'b1;
    logic            stray_done = 1'b0;

    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic [IW-1:0]   resp_id;
    logic [31:0]     resp_result;
    logic [2:0]      resp_flags;
    logic            busy, div_start, sqrt_start;
    logic [31:0]     op_a, op_b;
    logic [1:0]      op_rm;
    logic [5:0]      op_pc;
    logic            unit_done;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;

    int unit_lat = 2;
    int unit_cnt = 0;
    int div_starts = 0, sqrt_starts = 0, both_starts = 0;
    logic        mock_done  = 1'b0;
    logic [31:0] mock_res   = '0;
    logic [2:0]  mock_flags = '0;
    logic        m_sqrt = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [1:0]  m_rm = '0;
    logic [5:0]  m_pc = '0;

    assign unit_done = mock_done | stray_done;

    div_sqrt_arbiter_tp #(.NUM_REQ(N)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .Req_valid_SI(req_valid), .Req_ready_SO(req_ready), .Req_sqrt_SI(req_sqrt),
        .Req_operand_a_DI(req_a), .Req_operand_b_DI(req_b),
        .Req_rm_DI(req_rm), .Req_pc_DI(req_pc),
        .Resp_valid_SO(resp_valid), .Resp_ready_SI(resp_ready), .Resp_id_DO(resp_id),
        .Resp_result_DO(resp_result), .Resp_flags_DO(resp_flags), .Busy_SO(busy),
        .Div_start_SO(div_start), .Sqrt_start_SO(sqrt_start),
        .Operand_a_DO(op_a), .Operand_b_DO(op_b), .RM_SO(op_rm), .Precision_ctl_SO(op_pc),
        .Unit_ready_SI(unit_ready), .Unit_done_SI(unit_done),
        .Unit_result_DI(mock_res), .Unit_flags_DI(mock_flags)
    );

    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(f[30:23]) - 11'd127 + 11'd1023, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] unit_fn(logic s, logic [31:0] a, logic [31:0] b);
        return s ? r2f($sqrt(f2r(a))) : r2f(f2r(a) / f2r(b));
    endfunction

    // Stub flags fold rm/pc in so the bench can see them reach the unit intact.
    function automatic logic [2:0] flag_fn(logic s, logic [31:0] b, logic [1:0] rm, logic [5:0] pc);
        return {pc[0] ^ rm[1], rm[0], !s && (b[30:0] == 31'd0)};
    endfunction

    function automatic logic [31:0] rand_fp(logic sign);
        return {sign, 8'(100 + $urandom_range(50)), 23'($urandom)};
    endfunction

    function automatic int model_grant(logic [N-1:0] mask, int ptr);
        for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] exp_result(int i);
        return unit_fn(req_sqrt[i], req_a[32*i +: 32], req_b[32*i +: 32]);
    endfunction

    function automatic logic [2:0] exp_flags(int i);
        return flag_fn(req_sqrt[i], req_b[32*i +: 32], req_rm[2*i +: 2], req_pc[6*i +: 6]);
    endfunction

    always @(posedge clk) begin
        mock_done <= 1'b0;
        if (div_start && sqrt_start) both_starts <= both_starts + 1;
        if (div_start)  div_starts  <= div_starts + 1;
        if (sqrt_start) sqrt_starts <= sqrt_starts + 1;
        if (div_start || sqrt_start) begin
            unit_cnt <= unit_lat;
            m_sqrt   <= sqrt_start;
            m_a      <= op_a;
            m_b      <= op_b;
            m_rm     <= op_rm;
            m_pc     <= op_pc;
        end else if (unit_cnt > 0) begin
            unit_cnt <= unit_cnt - 1;
            if (unit_cnt == 1) begin
                mock_done  <= 1'b1;
                mock_res   <= unit_fn(m_sqrt, m_a, m_b);
                mock_flags <= flag_fn(m_sqrt, m_b, m_rm, m_pc);
            end
        end
    end

    task automatic set_req(input int i, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm, input logic [5:0] pc);
        req_sqrt[i]       = s;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_rm[2*i +: 2]  = rm;
        req_pc[6*i +: 6]  = pc;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(1)), rand_fp(1'b0), rand_fp(1'($urandom_range(1))),
                2'($urandom), 6'($urandom));
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (req_ready !== '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (resp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; unit_ready = 1'b1; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        total++;
        if ({busy, resp_valid, div_start, sqrt_start} !== 4'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 0000", {busy, resp_valid, div_start, sqrt_start});
        end
        total++;
        if ({op_a, op_b, op_rm, op_pc} !== '0) begin
            bad++; $display("FAIL reset_operands: got %h %h %h %h want 0", op_a, op_b, op_rm, op_pc);
        end
        total++;
        if ({resp_id, resp_result, resp_flags} !== '0) begin
            bad++; $display("FAIL reset_resp: got %h %h %h want 0", resp_id, resp_result, resp_flags);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_single_div();
        bit ok;
        int d0, s0;
        d0 = div_starts; s0 = sqrt_starts;
        set_req(0, 1'b0, 32'h4040_0000, 32'h4000_0000, 2'd0, 6'd0);
        req_valid = 4'b0001;
        wait_ready(ok);
        total++;
        if (!ok || req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        model_ptr = 1;
        @(negedge clk);
        req_valid = '0;
        #1;
        total++;
        if ({busy, div_start, sqrt_start} !== 3'b110) begin
            bad++; $display("FAIL single_start: got %b want 110", {busy, div_start, sqrt_start});
        end
        @(negedge clk); #1;
        total++;
        if ({div_start, sqrt_start} !== 2'b00) begin
            bad++; $display("FAIL single_pulse_width: got %b want 00", {div_start, sqrt_start});
        end
        wait_resp(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_resp_timeout: got none want resp"); end
        total++;
        if ({resp_id, resp_result, resp_flags} !== {2'd0, 32'h3FC0_0000, 3'd0}) begin
            bad++; $display("FAIL single_data: got %h %h %h want 0 3fc00000 0", resp_id, resp_result, resp_flags);
        end
        total++;
        if ((div_starts - d0) != 1 || (sqrt_starts - s0) != 0) begin
            bad++; $display("FAIL single_start_count: got div=%0d sqrt=%0d want 1 0", div_starts - d0, sqrt_starts - s0);
        end
        resp_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({resp_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL single_handshake: got %b want 00", {resp_valid, busy});
        end
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sqrt();
        bit ok;
        set_req(1, 1'b1, 32'h4080_0000, rand_fp(1'b0), 2'd0, 6'd0);
        req_valid = 4'b0010;
        wait_ready(ok);
        total++;
        if (!ok || req_ready !== 4'b0010) begin bad++; $display("FAIL sqrt_grant: got %b want 0010", req_ready); end
        model_ptr = 2;
        @(negedge clk);
        req_valid = '0;
        #1;
        total++;
        if ({div_start, sqrt_start} !== 2'b01) begin
            bad++; $display("FAIL sqrt_start: got %b want 01", {div_start, sqrt_start});
        end
        wait_resp(ok);
        total++;
        if (!ok || {resp_id, resp_result, resp_flags} !== {2'd1, 32'h4000_0000, 3'd0}) begin
            bad++; $display("FAIL sqrt_data: got %h %h %h want 1 40000000 0", resp_id, resp_result, resp_flags);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_fairness();
        bit ok;
        int exp_id;
        logic [31:0] er;
        logic [2:0] ef;
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = '1;
        resp_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            wait_ready(ok);
            exp_id = model_ptr;
            er = exp_result(exp_id);
            ef = exp_flags(exp_id);
            total++;
            if (!ok || req_ready !== (N'(1) << exp_id)) begin
                bad++; $display("FAIL fair_grant op%0d: got %b want %b", op, req_ready, N'(1) << exp_id);
            end
            @(posedge clk); #1;
            rand_req(exp_id);
            model_ptr = (model_ptr + 1) % N;
            unit_lat = 1 + $urandom_range(4);
            wait_resp(ok);
            total++;
            if (!ok || resp_id !== IW'(exp_id)) begin
                bad++; $display("FAIL fair_id op%0d: got %0d want %0d", op, resp_id, exp_id);
            end
            total++;
            if ({resp_result, resp_flags} !== {er, ef}) begin
                bad++; $display("FAIL fair_data op%0d: got %h %h want %h %h", op, resp_result, resp_flags, er, ef);
            end
            @(negedge clk);
        end
        req_valid = '0;
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ok;
        int exp_id;
        logic [N-1:0] mask;
        logic [31:0] er;
        logic [2:0] ef;
        for (int op = 0; op < 20; op++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) rand_req(i);
            req_valid = mask;
            wait_ready(ok);
            exp_id = model_grant(mask, model_ptr);
            er = exp_result(exp_id);
            ef = exp_flags(exp_id);
            total++;
            if (!ok || req_ready !== (N'(1) << exp_id)) begin
                bad++; $display("FAIL rand_grant op%0d mask=%b: got %b want %b", op, mask, req_ready, N'(1) << exp_id);
            end
            @(posedge clk); #1;
            req_valid = '0;
            model_ptr = (exp_id + 1) % N;
            unit_lat = 1 + $urandom_range(5);
            wait_resp(ok);
            total++;
            if (!ok || {resp_id, resp_result, resp_flags} !== {IW'(exp_id), er, ef}) begin
                bad++; $display("FAIL rand_resp op%0d: got %h %h %h want %h %h %h",
                                op, resp_id, resp_result, resp_flags, exp_id, er, ef);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end
        total++;
        if (both_starts != 0) begin bad++; $display("FAIL dual_start: got %0d want 0", both_starts); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] er;
        logic [2:0] ef;
        rand_req(3);
        req_valid = 4'b1000;
        wait_ready(ok);
        er = exp_result(3);
        ef = exp_flags(3);
        total++;
        if (!ok || req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
        model_ptr = 0;
        @(posedge clk); #1;
        req_valid = 4'b0111;
        rand_req(3);
        wait_resp(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_resp_timeout: got none want resp"); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            total++;
            if ({resp_valid, req_ready, resp_id, resp_result, resp_flags} !== {1'b1, 4'b0000, 2'd3, er, ef}) begin
                bad++; $display("FAIL bp_hold c%0d: got %b %b %h %h %h want 1 0000 3 %h %h",
                                c, resp_valid, req_ready, resp_id, resp_result, resp_flags, er, ef);
            end
        end
        req_valid = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_unit_not_ready();
        bit ok;
        int st0;
        logic [31:0] er;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        #1;
        total++;
        if ({resp_valid, busy} !== 2'b00) begin bad++; $display("FAIL stray_idle: got %b want 00", {resp_valid, busy}); end
        unit_ready = 1'b0;
        set_req(2, 1'b0, rand_fp(1'b0), rand_fp(1'b0), 2'd0, 6'd0);
        req_valid = 4'b0100;
        wait_ready(ok);
        er = exp_result(2);
        total++;
        if (!ok || req_ready !== 4'b0100) begin bad++; $display("FAIL nr_grant: got %b want 0100", req_ready); end
        model_ptr = 3;
        st0 = div_starts + sqrt_starts;
        @(posedge clk); #1;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            stray_done = (c == 2);
            #1;
            total++;
            if ({div_start, sqrt_start, busy, resp_valid} !== 4'b0010) begin
                bad++; $display("FAIL nr_wait c%0d: got %b want 0010", c, {div_start, sqrt_start, busy, resp_valid});
            end
        end
        @(negedge clk);
        stray_done = 1'b0;
        unit_ready = 1'b1;
        #1;
        total++;
        if ({div_start, sqrt_start, resp_valid} !== 3'b100) begin
            bad++; $display("FAIL nr_start: got %b want 100", {div_start, sqrt_start, resp_valid});
        end
        wait_resp(ok);
        total++;
        if (!ok || resp_result !== er || (div_starts + sqrt_starts - st0) != 1) begin
            bad++; $display("FAIL nr_resp: got %h starts=%0d want %h starts=1", resp_result, div_starts + sqrt_starts - st0, er);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        bit leaked;
        rand_req(1);
        req_valid = 4'b0010;
        unit_lat = 20;
        wait_ready(ok);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || unit_cnt == 0) begin bad++; $display("FAIL rb_precondition: got busy=%b want 1", busy); end
        req_valid = 4'b0110;
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, busy, resp_valid, div_start, sqrt_start} !== 8'b0) begin
            bad++; $display("FAIL rb_ctl: got %b want 0", {req_ready, busy, resp_valid, div_start, sqrt_start});
        end
        total++;
        if ({op_a, op_b, op_rm, op_pc, resp_id, resp_result, resp_flags} !== '0) begin
            bad++; $display("FAIL rb_data: got %h %h %h %h want 0", op_a, op_b, resp_id, resp_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        model_ptr = 0;
        leaked = 1'b0;
        repeat (30) begin
            @(negedge clk); #1;
            if (resp_valid !== 1'b0 || busy !== 1'b0) leaked = 1'b1;
        end
        total++;
        if (leaked) begin bad++; $display("FAIL rb_discard: got resp after reset want none"); end
        unit_lat = 2;
        rand_req(1);
        rand_req(2);
        req_valid = 4'b0110;
        wait_ready(ok);
        total++;
        if (!ok || req_ready !== (N'(1) << model_grant(4'b0110, model_ptr))) begin
            bad++; $display("FAIL rb_next_grant: got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(ok);
        total++;
        if (!ok || resp_id !== 2'd1) begin bad++; $display("FAIL rb_next_id: got %0d want 1", resp_id); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_div();
        test_sqrt();
        test_fairness();
        test_random();
        test_backpressure();
        test_unit_not_ready();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
